// File: rtl/sram_tp_rd_ctrl.sv
// Read-side burst controller for the two-port SRAM macro. It issues reads against a
// credit count and streams the returned words through a small buffer on valid/ready.
module sram_tp_rd_ctrl #(
  parameter int ADR_WD    = 6,
  parameter int DAT_WD    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADR_WD-1:0] cmd_adr,
  input  logic [ADR_WD:0]   cmd_len,
  output logic              rd_ena,
  output logic [ADR_WD-1:0] rd_adr,
  input  logic [DAT_WD-1:0] rd_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DAT_WD-1:0] out_dat,
  output logic              out_lst
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW+1:0] DEPTH_V = (PW+2)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [ADR_WD-1:0] adr_cnt;
  logic [ADR_WD:0]   rem;
  logic              rd_lst;
  logic              p2_vld;
  logic              p2_lst;
  logic [DAT_WD:0]   buf_mem [BUF_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       buf_cnt;
  logic [PW+1:0]     occ;
  logic              accept;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;

  assign cmd_rdy = (state == IDLE);
  assign accept  = cmd_vld && cmd_rdy;
  assign out_vld = (buf_cnt != '0);
  assign out_dat = buf_mem[rptr][DAT_WD-1:0];
  assign out_lst = out_vld && buf_mem[rptr][DAT_WD];
  assign pop     = out_vld && out_rdy;
  assign push    = p2_vld;

  // Credit covers buffered words plus both pipeline stages (register + SRAM latency).
  assign occ = {1'b0, buf_cnt} + {{(PW+1){1'b0}}, rd_ena} + {{(PW+1){1'b0}}, p2_vld}
             - {{(PW+1){1'b0}}, pop};
  assign issue      = (state == ISSUE) && (occ < DEPTH_V);
  assign last_issue = issue && (rem == (ADR_WD+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && (cmd_len != '0)) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && out_lst) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_cnt <= '0;
      rem     <= '0;
      rd_ena  <= 1'b0;
      rd_adr  <= '0;
      rd_lst  <= 1'b0;
      p2_vld  <= 1'b0;
      p2_lst  <= 1'b0;
    end else begin
      if (accept) begin
        adr_cnt <= cmd_adr;
        rem     <= cmd_len;
      end else if (issue) begin
        adr_cnt <= adr_cnt + ADR_WD'(1);
        rem     <= rem - (ADR_WD+1)'(1);
      end
      rd_ena <= issue;
      rd_lst <= last_issue;
      if (issue) rd_adr <= adr_cnt;
      p2_vld <= rd_ena;
      p2_lst <= rd_lst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) begin
        buf_mem[wptr] <= {p2_lst, rd_dat};
        wptr          <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + (PW+1)'(1);
        2'b01:   buf_cnt <= buf_cnt - (PW+1)'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (buf_cnt == (PW+1)'(BUF_DEPTH))));

endmodule

// File: tb/tb_sram_tp_rd_ctrl.sv
// Scoreboard bench for sram_tp_rd_ctrl: commands push the expected word/address
// streams into queues and a negedge monitor checks what the DUT presents.
module tb_sram_tp_rd_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NW = 1 << AW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_adr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          rd_ena;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_dat = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_dat;
  logic          out_lst;

  sram_tp_rd_ctrl #(.ADR_WD(AW), .DAT_WD(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .rd_ena(rd_ena), .rd_adr(rd_adr),
    .rd_dat(rd_dat), .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .out_lst(out_lst)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NW];
  always @(posedge clk) if (rd_ena) rd_dat <= mem[rd_adr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW:0]   exp_q [$];
  logic [AW-1:0] adr_q [$];
  int occ = 0;
  int issue_cnt = 0;
  int pop_cnt = 0;
  int first_vld_cyc = -1;
  int last_pop_cyc = -1;
  int acc_cyc = 0;
  int rdy_mode = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  logic          prev_lst = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: address scoreboard, credit bound, stall stability, data scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (rd_ena) begin
        issue_cnt++;
        occ++;
        chk("occupancy_bound", 64'(occ <= DEPTH), 64'd1);
        if (adr_q.size() == 0) chk("unexpected_rd", 64'd1, 64'd0);
        else chk("rd_adr", 64'(rd_adr), 64'(adr_q.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_vld", 64'(out_vld), 64'd1);
        chk("stall_dat", 64'(out_dat), 64'(prev_dat));
        chk("stall_lst", 64'(out_lst), 64'(prev_lst));
      end
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_vld && out_rdy) begin
        logic [DW:0] e;
        if (exp_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_dat", 64'(out_dat), 64'(e[DW-1:0]));
          chk("out_lst", 64'(out_lst), 64'(e[DW]));
        end
        occ--;
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      prev_stall <= out_vld && !out_rdy;
      prev_dat   <= out_dat;
      prev_lst   <= out_lst;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = 1'($urandom % 2);
        default: out_rdy = !((cyc - acc_cyc) >= 3 && (cyc - acc_cyc) <= 10);
      endcase
    end
  end

  task automatic send_cmd(input int adr, input int len, output int t);
    cmd_adr = AW'(adr);
    cmd_len = (AW+1)'(len);
    cmd_vld = 1'b1;
    t = -1;
    for (int n = 0; n < 300 && t < 0; n++) begin
      @(negedge clk);
      if (cmd_rdy) begin
        t = cyc;
        acc_cyc = cyc;
        first_vld_cyc = -1;
        for (int i = 0; i < len; i++) begin
          exp_q.push_back({1'(i == len - 1), mem[(adr + i) % NW]});
          adr_q.push_back(AW'((adr + i) % NW));
        end
      end
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    if (t < 0) chk("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || adr_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_ena"}, 64'(rd_ena), 64'd0);
    chk({tag, "_rd_adr"}, 64'(rd_adr), 64'd0);
    chk({tag, "_out_vld"}, 64'(out_vld), 64'd0);
    chk({tag, "_out_dat"}, 64'(out_dat), 64'd0);
    chk({tag, "_out_lst"}, 64'(out_lst), 64'd0);
    chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'd1);
  endtask

  initial begin
    int t, t2, base;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst: latency, back-to-back delivery, cmd_rdy return.
    rdy_mode = 0;
    send_cmd(5, 4, t);
    wait_drain();
    @(negedge clk);
    chk("first_vld_latency", 64'(first_vld_cyc - t), 64'd4);
    chk("last_pop_cycle", 64'(last_pop_cyc - t), 64'd7);
    chk("cmd_rdy_after_burst", 64'(cmd_rdy), 64'd1);
    chk("cmd_rdy_cycle", 64'(cyc - last_pop_cyc), 64'd1);
    @(posedge clk);
    #1;

    // Address wrap.
    send_cmd(62, 4, t);
    wait_drain();

    // Backpressure window: only DEPTH reads may be outstanding while stalled.
    rdy_mode = 2;
    base = issue_cnt;
    send_cmd(20, 8, t);
    while (cyc < t + 11) @(posedge clk);
    #1;
    chk("bp_issued_during_stall", 64'(issue_cnt - base), 64'(DEPTH));
    wait_drain();
    rdy_mode = 0;

    // Full-length burst under random backpressure.
    rdy_mode = 1;
    base = pop_cnt;
    send_cmd($urandom_range(0, NW - 1), NW, t);
    wait_drain();
    chk("full_burst_pops", 64'(pop_cnt - base), 64'(NW));
    rdy_mode = 0;

    // Zero-length command followed immediately by another.
    send_cmd(9, 0, t);
    send_cmd(30, 3, t2);
    chk("len0_next_accept", 64'(t2 - t), 64'd1);
    wait_drain();

    // Reset mid-burst after three pops.
    base = pop_cnt;
    send_cmd(40, 10, t);
    for (int n = 0; n < 200 && pop_cnt < base + 3; n++) @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    adr_q.delete();
    occ = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = pop_cnt;
    send_cmd(0, 2, t);
    wait_drain();
    chk("post_reset_pops", 64'(pop_cnt - base), 64'd2);

    // Random commands.
    for (int k = 0; k < 12; k++) begin
      rdy_mode = int'($urandom % 2);
      send_cmd($urandom_range(0, NW - 1), $urandom_range(0, NW), t);
      wait_drain();
    end
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    chk("addr_queue_empty", 64'(adr_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
